fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the N-wide pipeline. It generalises the fixed two-lane XM/MW bypass to LANES issue lanes and DEPTH tracked post-issue stages. It holds its own registered shadow of in-flight destination registers, so the datapath no longer has to route latch fields into it. Each cycle it produces per-lane ALU operand bypass selects, a load-use / intra-bundle stall, and a saturating stall counter. It sits beside the DX latch and drives the operand muxes in front of every lane's ALU.

---
 rtl/fwd_pkg.sv | 27 ++
 rtl/fwd_match.sv | 47 ++++
 rtl/fwd_scoreboard.sv | 108 ++++++++++
 tb/tb_fwd_scoreboard.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// fwd_pkg : tracker entry type and bypass-select encoding for fwd_scoreboard
// Rev 1.0
// ============================================================================
package fwd_pkg;

  // Tracker rd fields are stored at this width; REG_BITS must not exceed it.
  localparam int unsigned RD_MAX_BITS = 8;

  localparam logic [RD_MAX_BITS-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                   valid;
    logic                   regwrite;
    logic                   is_load;
    logic [RD_MAX_BITS-1:0] rd;
  } trk_entry_t;

  function automatic int unsigned fwd_code(input int unsigned s,
                                           input int unsigned j,
                                           input int unsigned lanes);
    return s * lanes + j + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
// fwd_match : resolves one source operand against every tracked stage/lane
// Rev 1.0
// ============================================================================
module fwd_match
  import fwd_pkg::*;
#(
  parameter int LANES            = 2,
  parameter int DEPTH            = 2,
  parameter int REG_BITS         = 5,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SELW             = 3
) (
  input  logic                         valid_i,
  input  logic [REG_BITS-1:0]          src_i,
  input  trk_entry_t [DEPTH*LANES-1:0] entries_i,
  output logic [SELW-1:0]              sel_o,
  output logic                         load_nr_o
);

  logic [RD_MAX_BITS-1:0] src_ext;
  assign src_ext = RD_MAX_BITS'(src_i);

  // Scan oldest stage / lowest lane first so the last hit is the winner:
  // youngest stage, then latest lane within that stage.
  always_comb begin
    sel_o     = '0;
    load_nr_o = 1'b0;
    if (valid_i && (src_ext != REG_ZERO)) begin
      for (int si = 0; si < DEPTH; si++) begin
        for (int j = 0; j < LANES; j++) begin
          if (entries_i[(DEPTH-1-si)*LANES + j].valid &&
              entries_i[(DEPTH-1-si)*LANES + j].regwrite &&
              (entries_i[(DEPTH-1-si)*LANES + j].rd != REG_ZERO) &&
              (entries_i[(DEPTH-1-si)*LANES + j].rd == src_ext)) begin
            sel_o     = SELW'(fwd_code(DEPTH-1-si, j, LANES));
            load_nr_o = entries_i[(DEPTH-1-si)*LANES + j].is_load &&
                        ((DEPTH-1-si) < LOAD_READY_STAGE);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// fwd_scoreboard : N-lane operand bypass selects, load-use/intra-bundle stall
// Rev 1.0
// ============================================================================
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int LANES            = 2,
  parameter  int DEPTH            = 2,
  parameter  int REG_BITS         = 5,
  parameter  int LOAD_READY_STAGE = 1,
  localparam int SELW             = $clog2(LANES*DEPTH+1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      adv_i,
  input  logic                      flush_i,
  input  logic [LANES-1:0]          iss_valid_i,
  input  logic [LANES-1:0]          iss_regwrite_i,
  input  logic [LANES-1:0]          iss_is_load_i,
  input  logic [LANES*REG_BITS-1:0] iss_rd_i,
  input  logic [LANES*REG_BITS-1:0] iss_rs_i,
  input  logic [LANES*REG_BITS-1:0] iss_rt_i,
  output logic [LANES*SELW-1:0]     fwd_sel_a_o,
  output logic [LANES*SELW-1:0]     fwd_sel_b_o,
  output logic                      stall_o,
  output logic [15:0]               stall_count_o
);

  trk_entry_t [DEPTH*LANES-1:0] trk_q, trk_d;
  trk_entry_t [LANES-1:0]       bundle;
  logic       [LANES-1:0]       lu_a, lu_b, intra;
  logic       [15:0]            cnt_q, cnt_d;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign bundle[g].valid    = iss_valid_i[g];
    assign bundle[g].regwrite = iss_regwrite_i[g];
    assign bundle[g].is_load  = iss_is_load_i[g];
    assign bundle[g].rd       = RD_MAX_BITS'(iss_rd_i[g*REG_BITS +: REG_BITS]);

    fwd_match #(
      .LANES(LANES), .DEPTH(DEPTH), .REG_BITS(REG_BITS),
      .LOAD_READY_STAGE(LOAD_READY_STAGE), .SELW(SELW)
    ) u_match_a (
      .valid_i   (iss_valid_i[g]),
      .src_i     (iss_rs_i[g*REG_BITS +: REG_BITS]),
      .entries_i (trk_q),
      .sel_o     (fwd_sel_a_o[g*SELW +: SELW]),
      .load_nr_o (lu_a[g])
    );

    fwd_match #(
      .LANES(LANES), .DEPTH(DEPTH), .REG_BITS(REG_BITS),
      .LOAD_READY_STAGE(LOAD_READY_STAGE), .SELW(SELW)
    ) u_match_b (
      .valid_i   (iss_valid_i[g]),
      .src_i     (iss_rt_i[g*REG_BITS +: REG_BITS]),
      .entries_i (trk_q),
      .sel_o     (fwd_sel_b_o[g*SELW +: SELW]),
      .load_nr_o (lu_b[g])
    );
  end

  // A later lane cannot read an older lane's result in the same bundle.
  always_comb begin
    intra = '0;
    for (int j = 1; j < LANES; j++) begin
      for (int i = 0; i < j; i++) begin
        if (iss_valid_i[i] && iss_regwrite_i[i] &&
            (iss_rd_i[i*REG_BITS +: REG_BITS] != '0) &&
            ((iss_rs_i[j*REG_BITS +: REG_BITS] == iss_rd_i[i*REG_BITS +: REG_BITS]) ||
             (iss_rt_i[j*REG_BITS +: REG_BITS] == iss_rd_i[i*REG_BITS +: REG_BITS]))) begin
          intra[j] = 1'b1;
        end
      end
    end
  end

  assign stall_o       = |(iss_valid_i & (lu_a | lu_b | intra));
  assign stall_count_o = cnt_q;

  always_comb begin
    trk_d = trk_q;
    cnt_d = cnt_q;
    if (adv_i) begin
      for (int s = DEPTH-1; s >= 1; s--) begin
        trk_d[s*LANES +: LANES] = trk_q[(s-1)*LANES +: LANES];
      end
      trk_d[LANES-1:0] = (stall_o || flush_i) ? '0 : bundle;
      if (stall_o && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_q <= '0;
      cnt_q <= '0;
    end else begin
      trk_q <= trk_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_fwd_scoreboard : directed + random checks against a pipeline-history model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fwd_scoreboard;

  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int RB    = 5;
  localparam int LRS   = 1;
  localparam int SELW  = $clog2(LANES*DEPTH+1);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                adv = 1'b1;
  logic                flush = 1'b0;
  logic [LANES-1:0]    v, w, l;
  logic [LANES*RB-1:0] rd, rs, rt;
  logic [LANES*SELW-1:0] sa, sb;
  logic                stall;
  logic [15:0]         cnt;

  int checks = 0;
  int errors = 0;

  // Model: what each stage holds, as a history of issued bundles (index 0 = most recent).
  bit mv [DEPTH][LANES];
  bit mw [DEPTH][LANES];
  bit ml [DEPTH][LANES];
  int mrd[DEPTH][LANES];
  int mcnt;

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .LANES(LANES), .DEPTH(DEPTH), .REG_BITS(RB), .LOAD_READY_STAGE(LRS)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .adv_i          (adv),
    .flush_i        (flush),
    .iss_valid_i    (v),
    .iss_regwrite_i (w),
    .iss_is_load_i  (l),
    .iss_rd_i       (rd),
    .iss_rs_i       (rs),
    .iss_rt_i       (rt),
    .fwd_sel_a_o    (sa),
    .fwd_sel_b_o    (sb),
    .stall_o        (stall),
    .stall_count_o  (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fa(input int j);
    return 32'(sa[j*SELW +: SELW]);
  endfunction

  function automatic logic [31:0] fb(input int j);
    return 32'(sb[j*SELW +: SELW]);
  endfunction

  function automatic int in_rd(input int j); return int'(rd[j*RB +: RB]); endfunction
  function automatic int in_rs(input int j); return int'(rs[j*RB +: RB]); endfunction
  function automatic int in_rt(input int j); return int'(rt[j*RB +: RB]); endfunction

  task automatic m_reset();
    for (int s = 0; s < DEPTH; s++)
      for (int j = 0; j < LANES; j++) begin
        mv[s][j] = 0; mw[s][j] = 0; ml[s][j] = 0; mrd[s][j] = 0;
      end
    mcnt = 0;
  endtask

  // Youngest stage first, latest lane first: the first hit wins.
  function automatic int m_sel(input bit lv, input int src, output bit lu);
    lu = 0;
    if (!lv || src == 0) return 0;
    for (int s = 0; s < DEPTH; s++)
      for (int j = LANES-1; j >= 0; j--)
        if (mv[s][j] && mw[s][j] && mrd[s][j] != 0 && mrd[s][j] == src) begin
          lu = ml[s][j] && (s < LRS);
          return s*LANES + j + 1;
        end
    return 0;
  endfunction

  function automatic bit m_stall();
    bit st = 0;
    bit lu;
    int k;
    for (int j = 0; j < LANES; j++) begin
      if (!v[j]) continue;
      k = m_sel(1'b1, in_rs(j), lu); if (lu) st = 1;
      k = m_sel(1'b1, in_rt(j), lu); if (lu) st = 1;
      for (int i = 0; i < j; i++)
        if (v[i] && w[i] && in_rd(i) != 0 &&
            (in_rs(j) == in_rd(i) || in_rt(j) == in_rd(i))) st = 1;
    end
    return st;
  endfunction

  task automatic check_model(input string tag);
    bit lu;
    for (int j = 0; j < LANES; j++) begin
      chk($sformatf("%s.sel_a%0d", tag, j), fa(j), m_sel(v[j], in_rs(j), lu));
      chk($sformatf("%s.sel_b%0d", tag, j), fb(j), m_sel(v[j], in_rt(j), lu));
    end
    chk($sformatf("%s.stall", tag), 32'(stall), 32'(m_stall()));
    chk($sformatf("%s.count", tag), 32'(cnt), mcnt);
  endtask

  task automatic tick();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (rst_n && adv) begin
      for (int s = DEPTH-1; s >= 1; s--)
        for (int j = 0; j < LANES; j++) begin
          mv[s][j] = mv[s-1][j]; mw[s][j] = mw[s-1][j];
          ml[s][j] = ml[s-1][j]; mrd[s][j] = mrd[s-1][j];
        end
      for (int j = 0; j < LANES; j++) begin
        if (!st && !flush) begin
          mv[0][j] = v[j]; mw[0][j] = w[j]; ml[0][j] = l[j]; mrd[0][j] = in_rd(j);
        end else begin
          mv[0][j] = 0; mw[0][j] = 0; ml[0][j] = 0; mrd[0][j] = 0;
        end
      end
      if (st && mcnt < 65535) mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    v = '0; w = '0; l = '0; rd = '0; rs = '0; rt = '0;
  endtask

  task automatic lane(input int j, input bit vv, input bit ww, input bit ll,
                      input int d, input int a, input int b);
    v[j] = vv; w[j] = ww; l[j] = ll;
    rd[j*RB +: RB] = RB'(d);
    rs[j*RB +: RB] = RB'(a);
    rt[j*RB +: RB] = RB'(b);
  endtask

  initial begin
    idle();
    m_reset();
    #1;
    check_model("reset");
    chk("reset.count0", 32'(cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_model("post_reset");

    // ALU write r5 on lane0, then consume from stage0 and stage1.
    lane(0, 1, 1, 0, 5, 0, 0); #1; check_model("t1"); tick();
    idle(); lane(1, 1, 0, 0, 0, 5, 0); #1; check_model("t2");
    chk("alu_s0.sel", fa(1), 1); chk("alu_s0.stall", 32'(stall), 0); tick();
    #1; check_model("t3"); chk("alu_s1.sel", fa(1), 3); tick();

    // Both lanes write r7: the later lane wins.
    idle(); lane(0, 1, 1, 0, 7, 0, 0); lane(1, 1, 1, 0, 7, 0, 0); #1; check_model("t4"); tick();
    idle(); lane(0, 1, 0, 0, 0, 0, 7); #1; check_model("t5"); chk("dual_s0.sel", fb(0), 2); tick();
    #1; check_model("t6"); chk("dual_s1.sel", fb(0), 4); tick();

    // Load-use on r9: one stall cycle, then forward from stage1.
    idle(); lane(0, 1, 1, 1, 9, 0, 0); #1; check_model("t7"); tick();
    idle(); lane(0, 1, 0, 0, 0, 9, 0); #1; check_model("t8"); chk("lu.stall", 32'(stall), 1); tick();
    #1; check_model("t9");
    chk("lu.sel", fa(0), 3); chk("lu.nostall", 32'(stall), 0); chk("lu.count", 32'(cnt), 1); tick();

    // Intra-bundle hazard and its non-hazard variants.
    idle(); lane(0, 1, 1, 0, 3, 0, 0); lane(1, 1, 0, 0, 0, 3, 0); #1; check_model("t10");
    chk("intra.stall", 32'(stall), 1); tick();
    idle(); lane(0, 1, 1, 0, 0, 0, 0); lane(1, 1, 0, 0, 0, 0, 0); #1; check_model("t11");
    chk("intra_r0.stall", 32'(stall), 0); chk("intra_r0.sel", fa(1), 0); tick();
    idle(); lane(0, 1, 0, 0, 3, 0, 0); lane(1, 1, 0, 0, 0, 3, 0); #1; check_model("t12");
    chk("intra_nowr.stall", 32'(stall), 0); chk("intra_nowr.sel", fa(1), 0); tick();

    // Flushed write must not become a producer.
    idle(); flush = 1'b1; lane(0, 1, 1, 0, 4, 0, 0); #1; check_model("t13"); tick();
    idle(); flush = 1'b0; lane(0, 1, 0, 0, 0, 4, 0); #1; check_model("t14");
    chk("flush.sel", fa(0), 0); tick();

    // Random traffic over a small register range to provoke frequent matches.
    for (int n = 0; n < 400; n++) begin
      adv   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < LANES; j++) begin
        bit rv, rw;
        rv = $urandom_range(0, 3) != 0;
        rw = $urandom_range(0, 2) != 0;
        lane(j, rv, rw, rw && ($urandom_range(0, 2) == 0),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
      #1;
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    // Asynchronous reset mid-stream.
    adv = 1'b1; flush = 1'b0;
    idle(); lane(0, 1, 0, 0, 0, 3, 5); lane(1, 1, 0, 0, 0, 7, 6);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_model("mid_reset");
    chk("mid_reset.sel_a0", fa(0), 0); chk("mid_reset.count", 32'(cnt), 0);
    tick();
    rst_n = 1'b1;
    #1; check_model("after_reset");

    // Saturation: hold an intra-bundle stall with adv=1.
    idle(); lane(0, 1, 1, 0, 3, 0, 0); lane(1, 1, 0, 0, 0, 3, 0); adv = 1'b1;
    #1; chk("sat.stall", 32'(stall), 1);
    repeat (70000) tick();
    #1; check_model("sat");
    chk("sat.count", 32'(cnt), 32'hFFFF);

    // adv=0 holds tracker and counter while stall is asserted.
    idle(); lane(0, 1, 1, 0, 6, 0, 0); #1; check_model("hold_issue"); tick();
    idle(); lane(0, 1, 1, 0, 3, 6, 0); lane(1, 1, 0, 0, 0, 3, 0); adv = 1'b0;
    #1; check_model("hold0");
    chk("hold0.sel", fa(0), 1); chk("hold0.stall", 32'(stall), 1);
    repeat (5) tick();
    #1; check_model("hold5");
    chk("hold5.sel", fa(0), 1); chk("hold5.count", 32'(cnt), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
